// File: rtl/pix_cap_pkg.sv
// Types and constants shared by the pixel-capture front end.
package pix_cap_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      WAIT_VS = 2'd1,
      ACTIVE  = 2'd2
   } cap_state_t;

   localparam int SYNC_DEPTH        = 2;
   localparam int DATA_W_DEF        = 8;
   localparam int BYTES_PER_PIX_DEF = 2;
   localparam int PIX_W             = DATA_W_DEF * BYTES_PER_PIX_DEF;

   function automatic int pix_width(input int data_w, input int bytes_per_pix);
      return data_w * bytes_per_pix;
   endfunction

endpackage

// File: rtl/cam_sync_edge.sv
// Multi-FF synchroniser with one extra history stage; rise/fall compare
// the last synchronised stage against the history stage.
module cam_sync_edge
   import pix_cap_pkg::*;
#(
   parameter int W = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [W-1:0] raw,
   output logic [W-1:0] sync,
   output logic [W-1:0] rise,
   output logic [W-1:0] fall
);

   logic [W-1:0] stage [SYNC_DEPTH+1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i <= SYNC_DEPTH; i++) stage[i] <= '0;
      end else begin
         stage[0] <= raw;
         for (int i = 1; i <= SYNC_DEPTH; i++) stage[i] <= stage[i-1];
      end
   end

   assign sync = stage[SYNC_DEPTH-1];
   assign rise = stage[SYNC_DEPTH-1] & ~stage[SYNC_DEPTH];
   assign fall = ~stage[SYNC_DEPTH-1] & stage[SYNC_DEPTH];

endmodule

// File: rtl/pix_cap_win.sv
// Camera pixel capture: oversampled sensor inputs, pixel assembly,
// horizontal crop into the line buffer, framing pulses and XCLK.
//
// state   | meaning
// IDLE    | capture disabled
// WAIT_VS | enabled, waiting for the first VSYNC rise
// ACTIVE  | inside a frame; lines are assembled and written
module pix_cap_win
   import pix_cap_pkg::*;
#(
   parameter int DATA_W        = 8,
   parameter int BYTES_PER_PIX = 2,
   parameter int ADDR_W        = 10,
   parameter int LINE_W        = 10,
   parameter int XCLK_DIV      = 4
) (
   input  logic                            CLK,
   input  logic                            RST_N,
   input  logic                            Enable,
   input  logic [ADDR_W-1:0]               WinXStart,
   input  logic [ADDR_W-1:0]               WinXEnd,
   input  logic                            CamPclk,
   input  logic                            CamHsync,
   input  logic                            CamVsync,
   input  logic [DATA_W-1:0]               CamData,
   output logic                            XCLK,
   output logic [ADDR_W-1:0]               LineWrAddr,
   output logic [DATA_W*BYTES_PER_PIX-1:0] LineWrData,
   output logic                            LineWrEn,
   output logic [LINE_W-1:0]               LineNum,
   output logic                            LineDone,
   output logic                            FrameStart,
   output logic                            FrameDone,
   output logic                            Busy,
   output logic                            ByteErr,
   output logic                            Overflow
);

   localparam int PIX_WIDTH = pix_width(DATA_W, BYTES_PER_PIX);
   localparam int BC_W      = (BYTES_PER_PIX > 1) ? $clog2(BYTES_PER_PIX) : 1;
   localparam int PX_W      = ADDR_W + 2;
   localparam int XC_W      = $clog2(XCLK_DIV);
   localparam logic [BC_W-1:0] LAST_BYTE = BC_W'(BYTES_PER_PIX - 1);
   localparam logic [PX_W-1:0] PX_MAX    = '1;

   logic pclk_sync_unused, pclk_rise, pclk_fall_unused;
   logic hs_sync, hs_rise, hs_fall;
   logic vs_sync_unused, vs_rise, vs_fall_unused;
   logic [DATA_W-1:0] data_sync, data_rise_unused, data_fall_unused;

   cam_sync_edge #(.W(1)) u_sync_pclk (
      .clk(CLK), .rst_n(RST_N), .raw(CamPclk),
      .sync(pclk_sync_unused), .rise(pclk_rise), .fall(pclk_fall_unused));
   cam_sync_edge #(.W(1)) u_sync_hs (
      .clk(CLK), .rst_n(RST_N), .raw(CamHsync),
      .sync(hs_sync), .rise(hs_rise), .fall(hs_fall));
   cam_sync_edge #(.W(1)) u_sync_vs (
      .clk(CLK), .rst_n(RST_N), .raw(CamVsync),
      .sync(vs_sync_unused), .rise(vs_rise), .fall(vs_fall_unused));
   cam_sync_edge #(.W(DATA_W)) u_sync_data (
      .clk(CLK), .rst_n(RST_N), .raw(CamData),
      .sync(data_sync), .rise(data_rise_unused), .fall(data_fall_unused));

   logic [XC_W-1:0] xclk_cnt;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         xclk_cnt <= '0;
         XCLK     <= 1'b0;
      end else begin
         xclk_cnt <= (xclk_cnt == XC_W'(XCLK_DIV - 1)) ? '0 : xclk_cnt + 1'b1;
         if (xclk_cnt == XC_W'(XCLK_DIV/2 - 1) || xclk_cnt == XC_W'(XCLK_DIV - 1))
            XCLK <= ~XCLK;
      end
   end

   cap_state_t           state;
   logic [BC_W-1:0]      byte_cnt, bc_eff;
   logic [PX_W-1:0]      px_cnt, px_eff, offset, start_x, end_x;
   logic [PIX_WIDTH-1:0] pix_asm, pix_next;
   logic                 take_byte, pix_done, in_win, beyond, do_write, do_ovf;

   // A line start coinciding with a byte makes that byte byte 0 of pixel 0.
   always_comb begin
      bc_eff    = hs_rise ? '0 : byte_cnt;
      px_eff    = hs_rise ? '0 : px_cnt;
      start_x   = {2'b00, WinXStart};
      end_x     = {2'b00, WinXEnd};
      take_byte = (state == ACTIVE) && pclk_rise && hs_sync;
      pix_done  = take_byte && (bc_eff == LAST_BYTE);
      pix_next  = PIX_WIDTH'({pix_asm, data_sync});
      offset    = px_eff - start_x;
      in_win    = (px_eff >= start_x) && (px_eff <= end_x);
      beyond    = (px_eff >= start_x) && (offset[PX_W-1:ADDR_W] != '0);
      do_write  = pix_done && in_win && !beyond;
      do_ovf    = pix_done && beyond;
   end

   assign Busy = (state == ACTIVE);

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state      <= IDLE;
         byte_cnt   <= '0;
         px_cnt     <= '0;
         pix_asm    <= '0;
         LineWrAddr <= '0;
         LineWrData <= '0;
         LineWrEn   <= 1'b0;
         LineNum    <= '0;
         LineDone   <= 1'b0;
         FrameStart <= 1'b0;
         FrameDone  <= 1'b0;
         ByteErr    <= 1'b0;
         Overflow   <= 1'b0;
      end else begin
         LineWrEn   <= 1'b0;
         LineDone   <= 1'b0;
         FrameStart <= 1'b0;
         FrameDone  <= 1'b0;
         case (state)
            IDLE: if (Enable) state <= WAIT_VS;
            WAIT_VS: begin
               if (!Enable) begin
                  state <= IDLE;
               end else if (vs_rise) begin
                  state      <= ACTIVE;
                  FrameStart <= 1'b1;
                  LineNum    <= '0;
                  ByteErr    <= 1'b0;
                  Overflow   <= 1'b0;
                  byte_cnt   <= '0;
                  px_cnt     <= '0;
               end
            end
            ACTIVE: begin
               if (hs_rise) begin
                  byte_cnt <= '0;
                  px_cnt   <= '0;
               end
               if (take_byte) begin
                  pix_asm <= pix_next;
                  if (pix_done) begin
                     byte_cnt <= '0;
                     px_cnt   <= (px_eff == PX_MAX) ? px_eff : px_eff + 1'b1;
                  end else begin
                     byte_cnt <= bc_eff + 1'b1;
                  end
               end
               if (do_write) begin
                  LineWrEn   <= 1'b1;
                  LineWrAddr <= offset[ADDR_W-1:0];
                  LineWrData <= pix_next;
               end
               if (do_ovf) Overflow <= 1'b1;
               if (hs_fall) begin
                  LineDone <= 1'b1;
                  LineNum  <= LineNum + 1'b1;
                  if (byte_cnt != '0) ByteErr <= 1'b1;
               end
               // Frame boundary overrides line-end updates made in the same cycle.
               if (vs_rise) begin
                  FrameDone <= 1'b1;
                  if (Enable) begin
                     FrameStart <= 1'b1;
                     LineNum    <= '0;
                     ByteErr    <= 1'b0;
                     Overflow   <= 1'b0;
                  end else begin
                     state <= IDLE;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_pix_cap_win.sv
// Directed bench for pix_cap_win: a default-size instance plus a 4-bit
// address instance sharing the same sensor stimulus.
module tb_pix_cap_win;

   logic        CLK = 1'b0;
   logic        RST_N;
   logic        Enable;
   logic [9:0]  win_start, win_end;
   logic [3:0]  win_start_s, win_end_s;
   logic        cam_pclk, cam_hsync, cam_vsync;
   logic [7:0]  cam_data;

   logic        xclk;
   logic [9:0]  wr_addr;
   logic [15:0] wr_data;
   logic        wr_en;
   logic [9:0]  line_num;
   logic        line_done, frame_start, frame_done, busy, byte_err, ovf;

   logic        s_xclk_unused;
   logic [3:0]  s_addr;
   logic [15:0] s_data;
   logic        s_wr_en;
   logic [9:0]  s_line_num_unused;
   logic        s_line_done_unused, s_frame_start_unused, s_frame_done_unused, s_busy_unused;
   logic        s_byte_err_unused, s_ovf;

   always #5 CLK = ~CLK;

   pix_cap_win dut (
      .CLK(CLK), .RST_N(RST_N), .Enable(Enable),
      .WinXStart(win_start), .WinXEnd(win_end),
      .CamPclk(cam_pclk), .CamHsync(cam_hsync), .CamVsync(cam_vsync), .CamData(cam_data),
      .XCLK(xclk), .LineWrAddr(wr_addr), .LineWrData(wr_data), .LineWrEn(wr_en),
      .LineNum(line_num), .LineDone(line_done), .FrameStart(frame_start),
      .FrameDone(frame_done), .Busy(busy), .ByteErr(byte_err), .Overflow(ovf));

   pix_cap_win #(.ADDR_W(4)) dut_s (
      .CLK(CLK), .RST_N(RST_N), .Enable(Enable),
      .WinXStart(win_start_s), .WinXEnd(win_end_s),
      .CamPclk(cam_pclk), .CamHsync(cam_hsync), .CamVsync(cam_vsync), .CamData(cam_data),
      .XCLK(s_xclk_unused), .LineWrAddr(s_addr), .LineWrData(s_data), .LineWrEn(s_wr_en),
      .LineNum(s_line_num_unused), .LineDone(s_line_done_unused),
      .FrameStart(s_frame_start_unused), .FrameDone(s_frame_done_unused),
      .Busy(s_busy_unused), .ByteErr(s_byte_err_unused), .Overflow(s_ovf));

   int checks = 0;
   int failures = 0;

   function automatic logic [7:0] byte_val(input int j);
      logic [7:0] i8;
      i8 = 8'(j / 2);
      return (j % 2 == 0) ? 8'hA0 + i8 : 8'h50 + i8;
   endfunction

   function automatic logic [15:0] pix_word(input int i);
      logic [7:0] i8;
      i8 = 8'(i);
      return {8'hA0 + i8, 8'h50 + i8};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Write/pulse monitor, sampled on the falling edge.
   logic [9:0]  wa_q[$];
   logic [15:0] wd_q[$];
   int ld_cnt, fs_cnt, fd_cnt, s_wr_cnt, s_seq_bad, cur_ws_s;

   always @(negedge CLK) begin
      if (wr_en) begin
         wa_q.push_back(wr_addr);
         wd_q.push_back(wr_data);
      end
      if (s_wr_en) begin
         if (s_addr != 4'(s_wr_cnt) || s_data != pix_word(cur_ws_s + s_wr_cnt)) s_seq_bad++;
         s_wr_cnt++;
      end
      if (line_done)   ld_cnt++;
      if (frame_start) fs_cnt++;
      if (frame_done)  fd_cnt++;
   end

   task automatic clear_mon();
      wa_q.delete();
      wd_q.delete();
      ld_cnt = 0; fs_cnt = 0; fd_cnt = 0; s_wr_cnt = 0; s_seq_bad = 0;
   endtask

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge CLK);
         #1;
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      cam_pclk = 1'b0;
      cam_data = b;
      tick(2);
      cam_pclk = 1'b1;
      tick(2);
   endtask

   task automatic send_line(input int nbytes);
      cam_pclk  = 1'b0;
      cam_hsync = 1'b1;
      tick(3);
      for (int j = 0; j < nbytes; j++) send_byte(byte_val(j));
      cam_pclk = 1'b0;
      tick(2);
      cam_hsync = 1'b0;
      tick(8);
   endtask

   task automatic vsync_pulse();
      cam_vsync = 1'b1;
      tick(4);
      cam_vsync = 1'b0;
      tick(4);
   endtask

   function automatic logic any_out();
      return |{xclk, wr_addr, wr_data, wr_en, line_num, line_done,
               frame_start, frame_done, busy, byte_err, ovf};
   endfunction

   typedef struct {
      int          ws, we, ws_s, we_s, nbytes;
      int          exp_wr, exp_last_addr;
      logic [15:0] exp_first, exp_last;
      logic        exp_err;
      int          exp_wr_s;
      logic        exp_ovf_s;
   } vec_t;

   vec_t vecs[6];

   initial begin
      //          ws   we    wss wes nbytes wr   last  first     last      err   wr_s ovf_s
      vecs[0] = '{0,   1023, 0,  15, 1280,  640, 639, 16'hA050, 16'h1FCF, 1'b0, 16, 1'b1};
      vecs[1] = '{100, 103,  4,  7,  208,   4,   3,   16'h04B4, 16'h07B7, 1'b0, 4,  1'b1};
      vecs[2] = '{0,   1023, 0,  15, 7,     3,   2,   16'hA050, 16'hA252, 1'b1, 3,  1'b0};
      vecs[3] = '{10,  5,    10, 5,  40,    0,   0,   16'h0000, 16'h0000, 1'b0, 0,  1'b0};
      vecs[4] = '{5,   5,    0,  15, 20,    1,   0,   16'hA555, 16'hA555, 1'b0, 10, 1'b0};
      vecs[5] = '{0,   1023, 0,  15, 40,    20,  19,  16'hA050, 16'hB363, 1'b0, 16, 1'b1};

      RST_N = 1'b0; Enable = 1'b0;
      win_start = '0; win_end = '0; win_start_s = '0; win_end_s = '0;
      cam_pclk = 1'b0; cam_hsync = 1'b0; cam_vsync = 1'b0; cam_data = '0;
      cur_ws_s = 0;
      clear_mon();

      for (int c = 0; c < 5; c++) begin
         @(negedge CLK);
         check($sformatf("reset_outs_%0d", c), 32'(any_out()), 0);
      end
      @(posedge CLK); #1;
      RST_N = 1'b1;

      begin
         logic [15:0] xs;
         int bad, highs;
         bad = 0; highs = 0;
         for (int i = 0; i < 16; i++) begin
            @(negedge CLK);
            xs[i] = xclk;
            highs += int'(xclk);
         end
         for (int i = 0; i < 12; i++) begin
            if (xs[i] !== xs[i+4]) bad++;
            if (xs[i] === xs[i+2]) bad++;
         end
         check("xclk_period", 32'(bad), 0);
         check("xclk_duty", 32'(highs), 8);
      end

      // Disabled: a VSYNC must not start a frame.
      tick(1);
      clear_mon();
      vsync_pulse();
      check("idle_no_frame", 32'(fs_cnt), 0);
      check("idle_busy", 32'(busy), 0);

      Enable = 1'b1;
      tick(2);

      for (int v = 0; v < 6; v++) begin
         int seq_bad;
         win_start   = 10'(vecs[v].ws);
         win_end     = 10'(vecs[v].we);
         win_start_s = 4'(vecs[v].ws_s);
         win_end_s   = 4'(vecs[v].we_s);
         cur_ws_s    = vecs[v].ws_s;
         clear_mon();
         vsync_pulse();
         check($sformatf("v%0d_frame_start", v), 32'(fs_cnt), 1);
         check($sformatf("v%0d_frame_done", v), 32'(fd_cnt), (v > 0) ? 1 : 0);
         check($sformatf("v%0d_busy", v), 32'(busy), 1);
         check($sformatf("v%0d_clr_err", v), {byte_err, ovf, s_ovf, 10'(line_num)}, 0);
         clear_mon();
         send_line(vecs[v].nbytes);
         check($sformatf("v%0d_writes", v), 32'(wa_q.size()), 32'(vecs[v].exp_wr));
         if (vecs[v].exp_wr > 0 && wa_q.size() > 0) begin
            check($sformatf("v%0d_first_addr", v), 32'(wa_q[0]), 0);
            check($sformatf("v%0d_first_data", v), 32'(wd_q[0]), 32'(vecs[v].exp_first));
            check($sformatf("v%0d_last_addr", v), 32'(wa_q[$]), 32'(vecs[v].exp_last_addr));
            check($sformatf("v%0d_last_data", v), 32'(wd_q[$]), 32'(vecs[v].exp_last));
         end
         seq_bad = 0;
         for (int k = 0; k < wa_q.size(); k++)
            if (wa_q[k] != 10'(k) || wd_q[k] != pix_word(vecs[v].ws + k)) seq_bad++;
         check($sformatf("v%0d_wr_seq", v), 32'(seq_bad), 0);
         check($sformatf("v%0d_byte_err", v), 32'(byte_err), 32'(vecs[v].exp_err));
         check($sformatf("v%0d_ovf", v), 32'(ovf), 0);
         check($sformatf("v%0d_line_done", v), 32'(ld_cnt), 1);
         check($sformatf("v%0d_line_num", v), 32'(line_num), 1);
         check($sformatf("v%0d_s_writes", v), 32'(s_wr_cnt), 32'(vecs[v].exp_wr_s));
         check($sformatf("v%0d_s_seq", v), 32'(s_seq_bad), 0);
         check($sformatf("v%0d_s_ovf", v), 32'(s_ovf), 32'(vecs[v].exp_ovf_s));
      end

      // Enable dropped mid-line: the frame runs to its end.
      win_start = 10'd0; win_end = 10'd1023;
      clear_mon();
      vsync_pulse();
      check("stop_frame_done", 32'(fd_cnt), 1);
      clear_mon();
      cam_hsync = 1'b1;
      tick(3);
      for (int j = 0; j < 20; j++) begin
         if (j == 10) Enable = 1'b0;
         send_byte(byte_val(j));
      end
      cam_pclk = 1'b0;
      tick(2);
      cam_hsync = 1'b0;
      tick(8);
      check("stop_writes", 32'(wa_q.size()), 10);
      check("stop_line_done", 32'(ld_cnt), 1);
      check("stop_busy_hold", 32'(busy), 1);
      clear_mon();
      vsync_pulse();
      check("stop_fd", 32'(fd_cnt), 1);
      check("stop_no_fs", 32'(fs_cnt), 0);
      check("stop_busy", 32'(busy), 0);
      send_line(8);
      check("stop_idle_writes", 32'(wa_q.size() + ld_cnt), 0);

      // Reset asserted mid-line.
      Enable = 1'b1;
      tick(2);
      clear_mon();
      vsync_pulse();
      check("rst_pre_fs", 32'(fs_cnt), 1);
      cam_hsync = 1'b1;
      tick(3);
      send_byte(byte_val(0));
      send_byte(byte_val(1));
      begin
         bit seen;
         seen = 1'b0;
         for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge CLK);
            if (wr_en) seen = 1'b1;
         end
         check("rst_wait_wr", 32'(seen), 1);
      end
      #1 RST_N = 1'b0;
      #1 check("rst_async_outs", 32'(any_out()), 0);
      tick(3);
      send_byte(byte_val(2));
      send_byte(byte_val(3));
      RST_N = 1'b1;
      clear_mon();
      for (int j = 4; j < 12; j++) send_byte(byte_val(j));
      cam_pclk = 1'b0;
      tick(2);
      cam_hsync = 1'b0;
      tick(8);
      check("rst_no_writes", 32'(wa_q.size()), 0);
      check("rst_no_line", 32'(ld_cnt + fs_cnt), 0);
      check("rst_busy", 32'(busy), 0);
      vsync_pulse();
      check("rst_fresh_fs", 32'(fs_cnt), 1);
      clear_mon();
      send_line(8);
      check("rst_after_writes", 32'(wa_q.size()), 4);
      check("rst_after_line_num", 32'(line_num), 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
